// File: rtl/servo_sched_pkg.sv
// Shared constants, FSM state type and channel priority encoder for the servo scheduler.
package servo_sched_pkg;

  localparam int         NUM_CH     = 6;
  localparam int         POS_W      = 10;
  localparam int         CENTER_POS = 512;
  localparam logic [2:0] NO_CH      = 3'd7;

  typedef enum logic {WAIT, PULSE} state_t;

  // Lowest enabled channel at or above 'from'; NO_CH when none remain.
  function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = NO_CH;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Timing-tick prescaler: tick is high for one clk cycle out of every TICK_DIV.
// Combinational tick from a registered count; free-running, no backpressure.
module servo_tick_gen #(
  parameter int TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_scheduler.sv
// Six-channel servo scheduler: one shared pulse counter pulses enabled channels back to back each frame.
// Registered outputs, no backpressure; define SERVO_SCHED_CLAMP_EN to clamp shadow positions to [POS_MIN, POS_MAX].
module servo_scheduler
  import servo_sched_pkg::*;
#(
  parameter int TICK_DIV    = 16,
  parameter int FRAME_TICKS = 20000,
  parameter int MIN_TICKS   = 500,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [POS_W-1:0] wr_pos,
  input  logic [5:0]       ch_en,
  output logic [5:0]       servo_out,
  output logic             frame_start,
  output logic [2:0]       active_ch,
  output logic             overrun
);

`ifdef SERVO_SCHED_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  localparam int FW = $clog2(FRAME_TICKS);

  function automatic logic [POS_W-1:0] shadow_val(input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] v;
    v = pos;
    if (CLAMP_ON) begin
      if (int'(v) < POS_MIN) v = POS_W'(POS_MIN);
      if (int'(v) > POS_MAX) v = POS_W'(POS_MAX);
    end
    return v;
  endfunction

  function automatic logic [11:0] width_of(input logic [POS_W-1:0] pos);
    return 12'(MIN_TICKS) + {1'b0, pos, 1'b0};
  endfunction

  logic              tick;
  logic [FW-1:0]     frame_cnt;
  logic              boundary;
  logic              wr_hit;
  logic [POS_W-1:0]  pending    [NUM_CH];
  logic [POS_W-1:0]  shadow     [NUM_CH];
  logic [POS_W-1:0]  shadow_nxt [NUM_CH];
  logic [NUM_CH-1:0] shadow_mask;
  state_t            state, state_nxt;
  logic [2:0]        ch_nxt, first_ch, after_ch;
  logic [11:0]       pulse_cnt, pulse_nxt;
  logic              ovr_nxt;

  servo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && (frame_cnt == FW'(FRAME_TICKS - 1));
  assign wr_hit   = wr_en && (wr_ch < 3'(NUM_CH));
  assign first_ch = next_ch(ch_en, 3'd0);
  assign after_ch = next_ch(shadow_mask, active_ch + 3'd1);

  // A write in the boundary cycle bypasses straight into the new frame's shadow.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_nxt[i] = shadow_val((wr_hit && (wr_ch == 3'(i))) ? wr_pos : pending[i]);
    end
  end

  // Pulse ends on the tick that would take the counter to zero, giving exactly width ticks.
  always_comb begin
    state_nxt = state;
    ch_nxt    = active_ch;
    pulse_nxt = pulse_cnt;
    ovr_nxt   = 1'b0;
    if (boundary) begin
      ovr_nxt = (state == PULSE) && !((pulse_cnt == 12'd1) && (after_ch == NO_CH));
      if (first_ch == NO_CH) begin
        state_nxt = WAIT;
        ch_nxt    = NO_CH;
      end else begin
        state_nxt = PULSE;
        ch_nxt    = first_ch;
        pulse_nxt = width_of(shadow_nxt[first_ch]);
      end
    end else if ((state == PULSE) && tick) begin
      if (pulse_cnt == 12'd1) begin
        if (after_ch == NO_CH) begin
          state_nxt = WAIT;
          ch_nxt    = NO_CH;
        end else begin
          ch_nxt    = after_ch;
          pulse_nxt = width_of(shadow[after_ch]);
        end
      end else begin
        pulse_nxt = pulse_cnt - 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      shadow_mask <= '0;
      state       <= WAIT;
      active_ch   <= NO_CH;
      pulse_cnt   <= '0;
      servo_out   <= '0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= POS_W'(CENTER_POS);
        shadow[i]  <= POS_W'(CENTER_POS);
      end
    end else begin
      if (tick) frame_cnt <= boundary ? '0 : frame_cnt + FW'(1);
      if (wr_hit) pending[wr_ch] <= wr_pos;
      if (boundary) begin
        shadow      <= shadow_nxt;
        shadow_mask <= ch_en;
      end
      state       <= state_nxt;
      active_ch   <= ch_nxt;
      pulse_cnt   <= pulse_nxt;
      servo_out   <= (state_nxt == PULSE) ? (6'd1 << ch_nxt) : 6'd0;
      frame_start <= boundary;
      overrun     <= ovr_nxt;
    end
  end

endmodule
